// File: rtl/pixel_cfg_sequencer_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : pixel_cfg_sequencer_if
//  Description : Request/status bundle between the SPI register file (master)
//                and the pixel configuration sequencer (slave), including the
//                column config bus and push clock toward the pixel array.
//  Revision    : 1.0 - initial release
// ============================================================================
interface pixel_cfg_sequencer_if #(
  parameter int N_COL = 4,
  parameter int CFG_W = 8
);

  // Request side, driven by the register file
  logic                   start;
  logic                   op;
  logic [1:0]             col_sel;
  logic [3:0]             row_sel;
  logic [CFG_W-1:0]       sel_byte;
  logic [CFG_W-1:0]       bg_byte;
  logic                   abort;

  // Status and array-facing side, driven by the sequencer
  logic                   busy;
  logic                   done;
  logic [CFG_W*N_COL-1:0] cfg_data;
  logic                   cfg_load;
  logic                   push_clk;
  logic [4:0]             push_cnt;

  // Register-file view: issues requests, observes status
  modport master (
    output start, op, col_sel, row_sel, sel_byte, bg_byte, abort,
    input  busy, done, cfg_data, cfg_load, push_clk, push_cnt
  );

  // Sequencer view: consumes requests, drives status and array signals
  modport slave (
    input  start, op, col_sel, row_sel, sel_byte, bg_byte, abort,
    output busy, done, cfg_data, cfg_load, push_clk, push_cnt
  );

endinterface
`default_nettype wire

// File: rtl/pixel_cfg_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : pixel_cfg_sequencer
//  Description : Drives the pixel-array configuration shift chain. One start
//                pulse presents a per-column config word and issues N_ROW
//                push clocks, leaving either one selected pixel at sel_byte
//                with all others at bg_byte, or the whole array cleared.
//  Revision    : 1.0 - initial release
// ============================================================================
module pixel_cfg_sequencer #(
  parameter int N_COL     = 4,
  parameter int N_ROW     = 16,
  parameter int CFG_W     = 8,
  parameter int PUSH_HIGH = 2,
  parameter int PUSH_LOW  = 2
) (
  input  wire logic            clk_40MHz,
  input  wire logic            rst,
  pixel_cfg_sequencer_if.slave bus
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam int c_CNT_MAX = (PUSH_HIGH > PUSH_LOW) ? PUSH_HIGH : PUSH_LOW;
  localparam int c_CNT_W   = (c_CNT_MAX > 1) ? $clog2(c_CNT_MAX) : 1;
  localparam int c_DATA_W  = CFG_W * N_COL;

  localparam logic [c_CNT_W-1:0] c_HIGH_LAST = c_CNT_W'(PUSH_HIGH - 1);
  localparam logic [c_CNT_W-1:0] c_LOW_LAST  = c_CNT_W'(PUSH_LOW - 1);
  localparam logic [4:0]         c_LAST_K    = 5'(N_ROW - 1);

  // --------------------------------------------------------------------------
  // State encoding
  // --------------------------------------------------------------------------
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_PH   = 3'd2,
    S_PL   = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t state_q, state_d;

  // Phase timer for the push_clk high/low phases
  logic [c_CNT_W-1:0] cnt_q, cnt_d;

  // Push index k; also exported as push_cnt
  logic [4:0] k_q, k_d;

  // Request captured at start so later input changes cannot disturb a run
  logic             op_q,  op_d;
  logic [1:0]       col_q, col_d;
  logic [3:0]       row_q, row_d;
  logic [CFG_W-1:0] sel_q, sel_d;
  logic [CFG_W-1:0] bg_q,  bg_d;

  // Registered outputs
  logic                busy_q,  busy_d;
  logic                done_q,  done_d;
  logic                load_q,  load_d;
  logic                pclk_q,  pclk_d;
  logic [c_DATA_W-1:0] data_q,  data_d;

  // Combinational helpers
  logic                w_abort;
  logic                w_hit;
  logic [c_DATA_W-1:0] w_image;

  // Abort only has meaning while a sequence is running; in IDLE start wins
  assign w_abort = (state_q != S_IDLE) && bus.abort;

  // --------------------------------------------------------------------------
  // Next-state logic: sequencing, phase timing, push index and request capture
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    k_d     = k_q;
    op_d    = op_q;
    col_d   = col_q;
    row_d   = row_q;
    sel_d   = sel_q;
    bg_d    = bg_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_LOAD;
          cnt_d   = '0;
          k_d     = '0;
          op_d    = bus.op;
          col_d   = bus.col_sel;
          row_d   = bus.row_sel;
          sel_d   = bus.sel_byte;
          bg_d    = bus.bg_byte;
        end
      end

      S_LOAD: begin
        state_d = S_PH;
        cnt_d   = '0;
      end

      S_PH: begin
        if (cnt_q == c_HIGH_LAST) begin
          state_d = S_PL;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + c_CNT_W'(1);
        end
      end

      S_PL: begin
        if (cnt_q == c_LOW_LAST) begin
          cnt_d = '0;
          if (k_q == c_LAST_K) begin
            state_d = S_DONE;
          end else begin
            state_d = S_LOAD;
            k_d     = k_q + 5'd1;
          end
        end else begin
          cnt_d = cnt_q + c_CNT_W'(1);
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    // A cancelled run drops straight back to IDLE; push index is left as-is
    if (w_abort) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end
  end

  // --------------------------------------------------------------------------
  // Column image for the upcoming push. Uses the _d view of the request so the
  // very first LOAD (entered directly from IDLE) sees the freshly captured data.
  // An out-of-range row never matches any push, giving an all-background image.
  // --------------------------------------------------------------------------
  always_comb begin
    w_hit   = 1'b0;
    w_image = '0;
    if (!op_d && (int'(row_d) < N_ROW) && (int'(k_d) == (N_ROW - 1 - int'(row_d)))) begin
      w_hit = 1'b1;
    end
    for (int c = 0; c < N_COL; c++) begin
      if (op_d) begin
        w_image[c*CFG_W +: CFG_W] = '0;
      end else if (w_hit && (int'(col_d) == c)) begin
        w_image[c*CFG_W +: CFG_W] = sel_d;
      end else begin
        w_image[c*CFG_W +: CFG_W] = bg_d;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Output next values, decoded from the next state so every output is a flop.
  // cfg_data only changes on entry to LOAD (or on abort), which keeps it stable
  // across the whole PH/PL window and hence at every push_clk rising edge.
  // --------------------------------------------------------------------------
  always_comb begin
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
    load_d = (state_d == S_LOAD);
    pclk_d = (state_d == S_PH);
    data_d = data_q;
    if (state_d == S_LOAD) begin
      data_d = w_image;
    end
    if (w_abort) begin
      data_d = '0;
    end
  end

  // State, phase timer, push index and captured request registers
  always_ff @(posedge clk_40MHz or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      k_q     <= '0;
      op_q    <= 1'b0;
      col_q   <= '0;
      row_q   <= '0;
      sel_q   <= '0;
      bg_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      k_q     <= k_d;
      op_q    <= op_d;
      col_q   <= col_d;
      row_q   <= row_d;
      sel_q   <= sel_d;
      bg_q    <= bg_d;
    end
  end

  // Output registers toward the register file and the pixel array
  always_ff @(posedge clk_40MHz or posedge rst) begin
    if (rst) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
      load_q <= 1'b0;
      pclk_q <= 1'b0;
      data_q <= '0;
    end else begin
      busy_q <= busy_d;
      done_q <= done_d;
      load_q <= load_d;
      pclk_q <= pclk_d;
      data_q <= data_d;
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.cfg_load = load_q;
  assign bus.push_clk = pclk_q;
  assign bus.cfg_data = data_q;
  assign bus.push_cnt = k_q;

endmodule
`default_nettype wire

// File: doc/pixel_cfg_sequencer.md
Name: pixel_cfg_sequencer

Overview:
Hardware sequencer for the pixel-array configuration shift chain, which today is driven by hand with SPI column writes followed by push commands. On one start pulse it presents a 4-column configuration word and issues N_ROW push clocks. The result is one selected pixel holding sel_byte, every other pixel holding bg_byte, or the whole array cleared. It sits between the SPI register file and the array's per-column config inputs and push_clk.

Parameters:
N_COL, 4, double columns in the array
N_ROW, 16, pixel rows per column (2 super-pixels x 8)
CFG_W, 8, config bits per column per row
PUSH_HIGH, 2, clk_40MHz cycles push_clk stays high
PUSH_LOW, 2, clk_40MHz cycles push_clk stays low after each high phase

Ports:
clk_40MHz  in  1  system clock; all logic on rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  one-cycle request; sampled only in IDLE
op  in  1  0 = single-pixel select, 1 = clear all (every byte 0)
col_sel  in  2  target column, 0..N_COL-1
row_sel  in  4  target row, 0..N_ROW-1 (row = y*8+z)
sel_byte  in  CFG_W  byte written to the target pixel (e.g. 0x3D)
bg_byte  in  CFG_W  byte written to all other pixels (e.g. 0x3C)
abort  in  1  synchronous cancel of a running sequence
busy  out  1  high while a sequence is running
done  out  1  one-cycle pulse on normal completion
cfg_data  out  CFG_W*N_COL  column c occupies bits [CFG_W*c+CFG_W-1 : CFG_W*c]
cfg_load  out  1  one-cycle pulse when cfg_data is updated for a new push
push_clk  out  1  shift clock to the array
push_cnt  out  5  index k of the current push, 0..N_ROW-1

Behaviour:
- Reset (async, any state): state=IDLE; busy, done, cfg_load, push_clk=0; cfg_data=0; push_cnt=0. A reset mid-sequence leaves a partial array image; software must re-issue the sequence.
- All outputs are registered.
- When start=1 in IDLE, latch op, col_sel, row_sel, sel_byte and bg_byte. Later changes to these inputs have no effect on the running sequence.
- start while busy is ignored and is not queued.
- Push mapping: data from push k ends in row N_ROW-1-k. The target pixel is therefore written at push k_t = N_ROW-1-row_sel.
- Data per push:
  - op=1: all columns get 0.
  - op=0, k==k_t: column col_sel gets sel_byte; all other columns get bg_byte.
  - op=0, other k: all columns get bg_byte.
- States:
  - IDLE: on start, go to LOAD with k=0.
  - LOAD (1 cycle): cfg_data updated; cfg_load=1; go to PH.
  - PH (PUSH_HIGH cycles): push_clk=1; go to PL.
  - PL (PUSH_LOW cycles): push_clk=0. If k==N_ROW-1, go to DONE; otherwise k+1 and go to LOAD.
  - DONE (1 cycle): done=1; go to IDLE.
- Timing: cfg_data is stable from LOAD through the end of PL, so it is stable at every push_clk rising edge.
- busy=1 in LOAD, PH, PL and DONE; 0 in IDLE.
- Latency: with start sampled at edge T, busy rises at T+1 and done is high during cycle T+1+N_ROW*(1+PUSH_HIGH+PUSH_LOW). With defaults, done is high at T+81.
- abort=1 in any non-IDLE state: next cycle state=IDLE, push_clk=0, cfg_data=0, no done pulse.
- abort and start in the same IDLE cycle: start wins; abort is ignored in IDLE.
- abort during PH: push_clk falls on the next edge, leaving a truncated high phase; this is accepted.
- push_cnt reflects k and holds its last value (N_ROW-1) after DONE until the next start.
- row_sel/col_sel out of range cannot occur with N_COL=4 and N_ROW=16. With other parameters, an out-of-range target is never matched, so the result is all bg_byte.

Test Plan:
- Reset: assert rst mid-PH → push_clk, busy and cfg_data go to 0 asynchronously; state returns to IDLE; a new start then runs a full 81-cycle sequence.
- op=0, col_sel=0, row_sel=0, sel=0x3D, bg=0x3C → 16 push_clk pulses. cfg_data=0x3C3C3C3C for k=0..14 and 0x3C3C3C3D at k=15; done at T+81.
- op=0, col_sel=3, row_sel=15 → cfg_data=0x3D3C3C3C at k=0 and 0x3C3C3C3C for every other k. A behavioural 16-deep shift model must hold 0x3D only at row 15, column 3.
- op=1 with any selectors → cfg_data=0 for all 16 pushes; exactly 16 push_clk rising edges; done pulses once.
- start asserted again at T+10 during busy, with different col_sel → ignored; cfg_data pattern unchanged; a single done.
- abort at k=5 → IDLE next cycle, push_clk=0, cfg_data=0, no done. A following start completes normally with push_cnt counting 0..15.
